// File: rtl/dvi_tmds_decoder.sv
// rtl/dvi_tmds_decoder.sv - TMDS channel receiver: word alignment by control-token runs and 10b->8b decode.
module dvi_tmds_decoder #(
  parameter int DATAWIDTH      = 8,
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int MAX_DATA_RUN   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           QIN,
  output logic [DATAWIDTH-1:0] D,
  output logic                 DE,
  output logic                 C0,
  output logic                 C1,
  output logic                 LOCKED,
  output logic [3:0]           OFFSET
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_DATA_RUN + 1);

  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);
  localparam logic [TW-1:0] TO_LAST  = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(SEARCH_TIMEOUT);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_DATA_RUN);

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  state_t               state;
  logic [9:0]           prev;
  logic [LW-1:0]        ctrl_cnt;
  logic [TW-1:0]        timeout_cnt;
  logic [RW-1:0]        data_run;

  logic [19:0]          pair;
  logic [9:0]           window;
  logic                 is_ctrl;
  logic [1:0]           ctrl_val;
  logic [DATAWIDTH-1:0] q;
  logic [DATAWIDTH-1:0] dec;
  logic [LW-1:0]        ctrl_inc;
  logic [TW-1:0]        timeout_inc;
  logic [RW-1:0]        run_inc;
  logic                 locked_next;

  always_comb begin
    pair   = {QIN, prev};
    window = 10'(pair >> OFFSET);

    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (window)
      10'b1101010100: ctrl_val = 2'b00;
      10'b0010101011: ctrl_val = 2'b01;
      10'b0101010100: ctrl_val = 2'b10;
      10'b1010101011: ctrl_val = 2'b11;
      default:        is_ctrl  = 1'b0;
    endcase

    // Undo the optional inversion, then undo the XOR/XNOR chain selected by bit 8.
    q      = window[9] ? ~window[DATAWIDTH-1:0] : window[DATAWIDTH-1:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < DATAWIDTH; i++) begin
      dec[i] = window[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    ctrl_inc    = !is_ctrl ? '0 : (ctrl_cnt == LOCK_MAX ? ctrl_cnt : ctrl_cnt + 1'b1);
    timeout_inc = (timeout_cnt == TO_MAX) ? timeout_cnt : timeout_cnt + 1'b1;
    run_inc     = is_ctrl ? '0 : (data_run == RUN_MAX ? data_run : data_run + 1'b1);

    // Outputs follow the lock state they will appear alongside.
    locked_next = (state == ST_SEARCH) ? (ctrl_inc == LOCK_MAX) : (run_inc != RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_SEARCH;
      prev        <= '0;
      ctrl_cnt    <= '0;
      timeout_cnt <= '0;
      data_run    <= '0;
      OFFSET      <= '0;
      LOCKED      <= 1'b0;
      D           <= '0;
      DE          <= 1'b0;
      C0          <= 1'b0;
      C1          <= 1'b0;
    end else begin
      prev <= QIN;
      case (state)
        ST_SEARCH: begin
          if (ctrl_inc == LOCK_MAX) begin
            state       <= ST_LOCKED;
            LOCKED      <= 1'b1;
            ctrl_cnt    <= '0;
            timeout_cnt <= '0;
            data_run    <= '0;
          end else if (timeout_cnt == TO_LAST) begin
            OFFSET      <= (OFFSET == 4'd9) ? 4'd0 : OFFSET + 4'd1;
            ctrl_cnt    <= '0;
            timeout_cnt <= '0;
          end else begin
            ctrl_cnt    <= ctrl_inc;
            timeout_cnt <= timeout_inc;
          end
        end
        ST_LOCKED: begin
          if (run_inc == RUN_MAX) begin
            state       <= ST_SEARCH;
            LOCKED      <= 1'b0;
            ctrl_cnt    <= '0;
            timeout_cnt <= '0;
            data_run    <= '0;
          end else begin
            data_run    <= run_inc;
          end
        end
        default: state <= ST_SEARCH;
      endcase

      if (!locked_next) begin
        D  <= '0;
        DE <= 1'b0;
        C0 <= 1'b0;
        C1 <= 1'b0;
      end else if (is_ctrl) begin
        DE <= 1'b0;
        C0 <= ctrl_val[0];
        C1 <= ctrl_val[1];
      end else begin
        DE <= 1'b1;
        D  <= dec;
      end
    end
  end

endmodule

// File: doc/dvi_tmds_decoder.md
Name: dvi_tmds_decoder

Overview:
- Receive-side counterpart of the DVI TMDS encoder; one instance per TMDS channel.
- Takes 10-bit parallel words from the deserializer. Word boundaries are unknown at arrival.
- Finds the boundary using control-token runs during blanking, then decodes each word back to 8-bit pixel data or control bits (C0, C1), with a data-enable flag.
- Sits between the deserializer and the pixel-stream consumer, for example a video capture or loopback check.

Parameters:
- DATAWIDTH, 8, decoded data width; only 8 is supported.
- LOCK_COUNT, 8, number of consecutive control tokens needed at one bit offset to declare lock.
- SEARCH_TIMEOUT, 1024, words allowed at one offset in SEARCH without reaching lock before the offset advances.
- MAX_DATA_RUN, 4096, consecutive non-control words allowed in LOCKED before lock is dropped.

Ports:
- clk, input, 1, word clock; one 10-bit word per cycle.
- reset, input, 1, synchronous, active-high.
- QIN, input, 10, raw deserialized word; bit 0 is the earliest serial bit.
- D, output, 8, decoded pixel data.
- DE, output, 1, data enable; 1 = video data word, 0 = control word.
- C0, output, 1, decoded control bit 0.
- C1, output, 1, decoded control bit 1.
- LOCKED, output, 1, word alignment is established.
- OFFSET, output, 4, current bit-slip offset, range 0..9.

Behaviour:
- Reset: D=0, DE=0, C0=0, C1=0, LOCKED=0, OFFSET=0, state=SEARCH, all counters 0.
- Alignment window: QIN is registered into prev each cycle. The window is bits [OFFSET+9:OFFSET] of the 20-bit value {QIN, prev}.
- Control tokens, checked on the window:
  - 0b1101010100 gives C1C0=00.
  - 0b0010101011 gives C1C0=01.
  - 0b0101010100 gives C1C0=10.
  - 0b1010101011 gives C1C0=11.
  - Any other word is treated as data.
- Data decode, where w is the window and q = w[9] ? ~w[7:0] : w[7:0]:
  - D[0] = q[0].
  - For i = 1..7: D[i] = w[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Latency: a word completed in the window at cycle N appears on D/DE/C0/C1 registered at the edge ending cycle N, i.e. visible at N+1. Total latency from QIN to outputs is 2 clocks at OFFSET=0.
- Output registers:
  - Control word: DE=0, C1C0 = decoded value, D holds its previous value.
  - Data word: DE=1, D = decoded value, C0 and C1 hold.
  - While LOCKED=0: DE is forced to 0, C0=C1=0, D=0.
- FSM state SEARCH:
  - Control token: ctrl_cnt++; timeout_cnt++.
  - Non-control word: ctrl_cnt=0; timeout_cnt++.
  - ctrl_cnt reaching LOCK_COUNT transitions to LOCKED; LOCKED=1 from the next cycle; timeout_cnt=0.
  - Otherwise, timeout_cnt reaching SEARCH_TIMEOUT-1 advances OFFSET by 1 (9 wraps to 0) and clears both counters.
  - If both conditions occur in the same cycle, lock wins and OFFSET is unchanged.
- FSM state LOCKED:
  - Control token clears data_run.
  - Non-control word increments data_run.
  - data_run reaching MAX_DATA_RUN transitions to SEARCH. LOCKED=0 next cycle, counters are cleared, OFFSET is retained, and the search resumes at that offset.
- OFFSET changes only in SEARCH. After a change, the first window at the new offset is evaluated on the next cycle with no holdoff.
- reset asserted mid-operation overrides everything and returns all state to reset values on the next edge.
- Counters saturate and never wrap. Counter widths are sized to hold their parameter value.

Test Plan:
- Reset, then 20 words of 0x354 (0b1101010100) at OFFSET 0 -> LOCKED rises after 8 tokens; DE=0, C1C0=00, OFFSET=0.
- Serial stream of 0x0AB tokens rotated by 3 bits, with SEARCH_TIMEOUT=16 -> OFFSET steps 0,1,2,... until aligned. LOCKED=1 with the window matching 0x0AB and C1C0=01.
- After lock, send data words 0x100 then 0x200 -> D=0x00 then D=0xFF, DE=1, each 2 clocks after entry.
- After lock, send tokens 0x154 and 0x2AB -> DE=0 with C1C0=10 then 11; D holds 0xFF.
- With MAX_DATA_RUN=32, send 32 consecutive data words -> LOCKED falls, outputs forced to 0, OFFSET unchanged. Subsequent tokens re-lock after 8 words.
- Assert reset for 1 cycle while locked mid-data -> next cycle LOCKED=0, OFFSET=0, D=0, DE=0, C0=C1=0.
